audio_sample_buffer: RTL and testbench

//   Consumer of the register file's audio outputs: captures the 11-bit R6 audio sample each time the

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_fifo.sv | 81 ++++++++
 rtl/audio_sample_buffer.sv | 132 +++++++++++++
 tb/tb_audio_sample_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample buffer.
package audio_pkg;

    localparam int SAMPLE_W = 11;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Idle DAC level: half of the 11-bit range
    localparam sample_t MIDSCALE = 11'd1024;

    // PWM counter width; the period is 2**PWM_W clk cycles
    localparam int PWM_W = 11;

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample FIFO with registered level/full/empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is dropped and reported on push_drop for that cycle.
module audio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       push_drop
);
    import audio_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Decide which operations take effect and the resulting occupancy
    always_comb begin
        do_pop_s    = pop & ~empty_r;
        do_push_s   = push & (~full_r | do_pop_s);
        push_drop   = push & full_r & ~do_pop_s;
        level_nxt_s = level_r;
        case ({do_push_s, do_pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_FULL);
            empty_r <= (level_nxt_s == '0);
        end
    end

    // Sample storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/audio_sample_buffer.sv
// Audio sample buffer: captures R6 samples on rising edges of the R14 flag,
// queues them and releases one per SAMPLE_DIV clocks to the DAC side.
// Optional feature macro: AUDIO_PWM_EN adds an 11-bit PWM DAC output (pwm_out).
module audio_sample_buffer #(
    parameter int DEPTH      = 16,
    parameter int SAMPLE_W   = 11,
    parameter int SAMPLE_DIV = 1134
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SAMPLE_W-1:0]        sample_in,
    input  logic                       flag_in,
    output logic [SAMPLE_W-1:0]        sample_out,
    output logic                       sample_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
`ifdef AUDIO_PWM_EN
    ,
    output logic                       pwm_out
`endif
);
    import audio_pkg::*;

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SAMPLE_DIV-1);
    localparam logic [SAMPLE_W-1:0] MID_S    = SAMPLE_W'(MIDSCALE);

    logic                flag_q_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [SAMPLE_W-1:0] sample_out_r;
    logic                valid_r;
    logic                overflow_r;
    logic                underflow_r;
    logic                push_s;
    logic                tick_s;
    logic                pop_s;
    logic                fifo_empty_s;
    logic                push_drop_s;
    logic [SAMPLE_W-1:0] head_s;

    // Edge detect on the flag, divider tick, and pop request
    always_comb begin
        push_s = flag_in & ~flag_q_r;
        tick_s = (cnt_r == CNT_LAST);
        pop_s  = tick_s & ~fifo_empty_s;
    end

    audio_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .wr_data   (sample_in),
        .rd_data   (head_s),
        .level     (level),
        .full      (full),
        .empty     (fifo_empty_s),
        .push_drop (push_drop_s)
    );

    // Flag history (reset high so a flag already high at release is not an edge) and sample-rate divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q_r <= 1'b1;
            cnt_r    <= '0;
        end else begin
            flag_q_r <= flag_in;
            if (tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Output sample register, valid pulse and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_out_r <= MID_S;
            valid_r      <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                sample_out_r <= head_s;
            end
            valid_r <= pop_s;
            if (push_drop_s) begin
                overflow_r <= 1'b1;
            end
            if (tick_s && fifo_empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign sample_out   = sample_out_r;
    assign sample_valid = valid_r;
    assign empty        = fifo_empty_s;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

`ifdef AUDIO_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_r;
    logic [PWM_W-1:0] duty_r;
    logic             pwm_r;

    // Free-running PWM; duty only changes at the start of a period to avoid glitchy periods
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_r <= '0;
            duty_r    <= PWM_W'(MIDSCALE);
            pwm_r     <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
            if (pwm_cnt_r == '0) begin
                duty_r <= PWM_W'(sample_out_r);
            end
            pwm_r <= (pwm_cnt_r < duty_r);
        end
    end

    assign pwm_out = pwm_r;
`endif

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer with DEPTH=4, SAMPLE_DIV=4.
// Cycle c is the interval after the c-th rising edge following reset release;
// the divider ticks in cycles 3, 7, 11, ... so pops land at edges 4, 8, 12, ...
module tb_audio_sample_buffer;

    logic        clk;
    logic        rst;
    logic [10:0] sample_in;
    logic        flag_in;
    logic [10:0] sample_out;
    logic        sample_valid;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
`ifdef AUDIO_PWM_EN
    logic        pwm_out;
`endif

    int n_vec;
    int n_mis;
    logic [10:0] vtab [1:9];

    audio_sample_buffer #(
        .DEPTH      (4),
        .SAMPLE_W   (11),
        .SAMPLE_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .flag_in      (flag_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef AUDIO_PWM_EN
        ,
        .pwm_out      (pwm_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for a few clocks, release just after an edge: caller is then in cycle 0
    task automatic do_reset(input logic flag_lvl);
        rst       = 1'b0;
        flag_in   = flag_lvl;
        sample_in = 11'h000;
        repeat (3) step();
        rst = 1'b1;
    endtask

    // Pushes on every odd cycle up to 17 (v1..v9); pops each tick
    task automatic burst_drive(input int c);
        if ((c % 2 == 1) && (c <= 17)) begin
            flag_in   = 1'b1;
            sample_in = vtab[(c + 1) / 2];
        end else begin
            flag_in   = 1'b0;
            sample_in = 11'h000;
        end
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        vtab[1] = 11'h001; vtab[2] = 11'h7FF; vtab[3] = 11'h400;
        vtab[4] = 11'h2AA; vtab[5] = 11'h555; vtab[6] = 11'h0F0;
        vtab[7] = 11'h30F; vtab[8] = 11'h123; vtab[9] = 11'h6D9;

        // Test 1: flag high across release is not a push
        do_reset(1'b1);
        chk("t1 level",     level,        32'd0);
        chk("t1 empty",     empty,        32'd1);
        chk("t1 full",      full,         32'd0);
        chk("t1 out",       sample_out,   32'd1024);
        chk("t1 valid",     sample_valid, 32'd0);
        chk("t1 overflow",  overflow,     32'd0);
        chk("t1 underflow", underflow,    32'd0);
`ifdef AUDIO_PWM_EN
        chk("t1 pwm",       pwm_out,      32'd0);
`endif
        step();
        chk("t1 level c1",  level,        32'd0);

        // Test 2: two samples released one per tick
        do_reset(1'b0);
        for (int c = 0; c < 14; c++) begin
            if (c == 7)  chk("t2 level c7", level, 32'd2);
            if (c == 8) begin
                chk("t2 out c8",   sample_out,   32'h155);
                chk("t2 valid c8", sample_valid, 32'd1);
                chk("t2 level c8", level,        32'd1);
            end
            if (c == 9)  chk("t2 valid c9", sample_valid, 32'd0);
            if (c == 11) chk("t2 out c11",  sample_out,   32'h155);
            if (c == 12) begin
                chk("t2 out c12",   sample_out,   32'h2AA);
                chk("t2 valid c12", sample_valid, 32'd1);
                chk("t2 level c12", level,        32'd0);
                chk("t2 empty c12", empty,        32'd1);
            end
            if (c == 13) chk("t2 valid c13", sample_valid, 32'd0);
            flag_in   = (c == 4) || (c == 6);
            sample_in = (c == 4) ? 11'h155 : 11'h2AA;
            step();
        end

        // Tests 3-5: fill, push on a full tick (kept), push on full non-tick (dropped), drain, underflow
        do_reset(1'b0);
        for (int c = 0; c < 37; c++) begin
            if (c == 3) chk("t3 level c3", level, 32'd1);
            if (c == 4) begin
                chk("t3 out c4",   sample_out,   {21'd0, vtab[1]});
                chk("t3 valid c4", sample_valid, 32'd1);
                chk("t3 level c4", level,        32'd1);
            end
            if (c == 5)  chk("t3 valid c5", sample_valid, 32'd0);
            if (c == 8)  chk("t3 out c8",   sample_out,   {21'd0, vtab[2]});
            if (c == 12) chk("t3 out c12",  sample_out,   {21'd0, vtab[3]});
            if (c == 14) begin
                chk("t3 level c14", level, 32'd4);
                chk("t3 full c14",  full,  32'd1);
            end
            if (c == 16) begin
                chk("t4 level c16",    level,      32'd4);
                chk("t4 overflow c16", overflow,   32'd0);
                chk("t4 out c16",      sample_out, {21'd0, vtab[4]});
            end
            if (c == 17) chk("t4 overflow c17", overflow, 32'd0);
            if (c == 18) begin
                chk("t3 overflow c18", overflow, 32'd1);
                chk("t3 level c18",    level,    32'd4);
            end
            if (c == 20) begin
                chk("t3 out c20",   sample_out, {21'd0, vtab[5]});
                chk("t3 level c20", level,      32'd3);
            end
            if (c == 24) chk("t3 out c24", sample_out, {21'd0, vtab[6]});
            if (c == 28) chk("t3 out c28", sample_out, {21'd0, vtab[7]});
            if (c == 32) begin
                chk("t3 out c32",   sample_out, {21'd0, vtab[8]});
                chk("t3 empty c32", empty,      32'd1);
            end
            if (c == 35) chk("t5 underflow c35", underflow, 32'd0);
            if (c == 36) begin
                chk("t5 underflow c36", underflow,    32'd1);
                chk("t5 out c36",       sample_out,   {21'd0, vtab[8]});
                chk("t5 valid c36",     sample_valid, 32'd0);
                chk("t5 overflow c36",  overflow,     32'd1);
            end
            burst_drive(c);
            step();
        end

        // Test 6: asynchronous reset while three samples are queued
        do_reset(1'b0);
        for (int c = 0; c < 21; c++) begin
            burst_drive(c);
            step();
        end
        chk("t6 level pre", level, 32'd3);
        rst = 1'b0;
        #1;
        chk("t6 level",     level,        32'd0);
        chk("t6 empty",     empty,        32'd1);
        chk("t6 full",      full,         32'd0);
        chk("t6 out",       sample_out,   32'd1024);
        chk("t6 valid",     sample_valid, 32'd0);
        chk("t6 overflow",  overflow,     32'd0);
        chk("t6 underflow", underflow,    32'd0);

`ifdef AUDIO_PWM_EN
        // PWM: sample 512 reaches duty at the next period start; count highs over one full period
        begin
            int highs;
            highs = 0;
            do_reset(1'b0);
            for (int c = 0; c < 4148; c++) begin
                if (c >= 2100) highs += int'(pwm_out);
                flag_in   = (c == 1);
                sample_in = 11'd512;
                step();
            end
            chk("t6 pwm highs", highs, 32'd512);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
